// File: rtl/cache_fill_controller.sv
// Cache fill controller: sequences a direct-mapped, 4-column data cache
// between the CPU and a burst memory port. Read hits are served from the
// cache. Read misses fetch the whole line as a 4-word burst and fill the
// cache column by column. Writes are write-through with no allocate on miss.
module cache_fill_controller #(
    parameter int COLUMN_IX_BITWIDTH = 2,
    parameter int ZEROS_BITWIDTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic        cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_valid,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    input  logic        mem_write_done
);

    localparam int COL_LO  = ZEROS_BITWIDTH;
    localparam int COL_HI  = ZEROS_BITWIDTH + COLUMN_IX_BITWIDTH - 1;
    localparam int LINE_LO = COL_HI + 1;
    localparam int OFS_W   = COLUMN_IX_BITWIDTH + ZEROS_BITWIDTH;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOOKUP     = 3'd1;
    localparam logic [2:0] FILL_CMD   = 3'd2;
    localparam logic [2:0] FILL       = 3'd3;
    localparam logic [2:0] WRITE_CMD  = 3'd4;
    localparam logic [2:0] WRITE_WAIT = 3'd5;

    logic [2:0]                    state;
    logic [31:0]                   addr_q;
    logic [31:0]                   wdata_q;
    logic                          is_write_q;
    logic [COLUMN_IX_BITWIDTH-1:0] beat;

    logic        req_accept;
    logic        last_beat;
    logic [31:0] line_addr;
    logic [31:0] fill_addr;

    // A request is taken only in IDLE and never in the completion cycle,
    // because the CPU still holds its request level while cpu_ready is high.
    assign req_accept = (state == IDLE) && !cpu_ready && (cpu_read || cpu_write);
    assign last_beat  = (beat == {COLUMN_IX_BITWIDTH{1'b1}});
    assign line_addr  = {addr_q[31:LINE_LO], {OFS_W{1'b0}}};
    assign fill_addr  = {addr_q[31:LINE_LO], beat, {ZEROS_BITWIDTH{1'b0}}};

    // Transaction sequencing: request latch, hit/miss decision, burst
    // counting and the registered CPU completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            beat       <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        addr_q     <= cpu_address;
                        wdata_q    <= cpu_wdata;
                        is_write_q <= cpu_write;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (is_write_q) begin
                        state <= WRITE_CMD;
                    end else if (cache_data_out_valid) begin
                        cpu_rdata <= cache_data_out;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= FILL_CMD;
                    end
                end
                FILL_CMD: begin
                    if (mem_cmd_ready) begin
                        beat  <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rdata_valid) begin
                        // The requested word goes straight to the CPU, so the
                        // cache does not have to be read again after the fill.
                        if (beat == addr_q[COL_HI:COL_LO]) begin
                            cpu_rdata <= mem_rdata;
                        end
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            cpu_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WRITE_CMD: begin
                    if (mem_cmd_ready) begin
                        state <= WRITE_WAIT;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_done) begin
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cache and memory port drive decoded from the state. The cache address
    // follows the CPU directly in IDLE so the tag/data lookup is already
    // valid in the LOOKUP cycle; commands are state-decoded so their fields
    // cannot change while waiting for acceptance.
    always_comb begin
        cache_address      = addr_q;
        cache_data_in      = '0;
        cache_write_enable = 1'b0;
        mem_cmd_valid      = 1'b0;
        mem_cmd_write      = 1'b0;
        mem_address        = '0;
        mem_wdata          = '0;
        case (state)
            IDLE: begin
                if (req_accept) begin
                    cache_address = cpu_address;
                end
            end
            LOOKUP: begin
                // Write hit updates the cached word; a write miss leaves the
                // cache untouched (no allocate).
                if (is_write_q && cache_data_out_valid) begin
                    cache_data_in      = wdata_q;
                    cache_write_enable = 1'b1;
                end
            end
            FILL_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_address   = line_addr;
            end
            FILL: begin
                cache_address      = fill_addr;
                cache_data_in      = mem_rdata;
                cache_write_enable = mem_rdata_valid;
            end
            WRITE_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_write = 1'b1;
                mem_address   = addr_q;
                mem_wdata     = wdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_fill_controller.md
Name: cache_fill_controller

Overview:
Sequences the 4-column direct-mapped data cache (one tag RAM plus 4 column RAMs, 1-cycle synchronous read) between the CPU and a burst memory port (PSRAM controller).
- Read hit: returns the word from the cache.
- Read miss: fetches the whole line from memory, fills the cache column by column, then returns the requested word.
- Writes are write-through, no-write-allocate. The cache's tag write always marks the line valid and clean, so a partial line is never written on a miss.

Parameters:
COLUMN_IX_BITWIDTH, 2, log2 of words per line; burst length is 2**COLUMN_IX_BITWIDTH words (4).
ZEROS_BITWIDTH, 2, byte-offset bits (word-aligned addressing).

Ports:
clk  in  1  system clock.
rst  in  1  reset; one clock; asynchronous, active-high.
cpu_address  in  32  word-aligned request address; held stable until cpu_ready.
cpu_read  in  1  read request; level, held until cpu_ready.
cpu_write  in  1  write request; level, held until cpu_ready.
cpu_wdata  in  32  write data.
cpu_rdata  out  32  read data; valid only while cpu_ready=1.
cpu_ready  out  1  one-cycle completion pulse.
cache_address  out  32  address to the cache (line/column/tag fields).
cache_data_in  out  32  data to the cache.
cache_write_enable  out  1  writes cache_data_in into column of cache_address and sets the line tag valid.
cache_data_out  in  32  cache word, 1 cycle after cache_address.
cache_data_out_valid  in  1  hit flag, 1 cycle after cache_address.
mem_cmd_valid  out  1  memory command request.
mem_cmd_ready  in  1  memory accepts the command in a cycle where both are 1.
mem_cmd_write  out  1  1 = single-word write, 0 = burst read of 4 words.
mem_address  out  32  command address; line-aligned (column bits 0) for burst reads.
mem_wdata  out  32  write data.
mem_rdata  in  32  burst read word.
mem_rdata_valid  in  1  one strobe per burst word, in column order 0..3.
mem_write_done  in  1  one-cycle pulse when the write has completed.

Behaviour:
- Reset (async assert): state IDLE. cpu_ready, cache_write_enable, mem_cmd_valid, mem_cmd_write = 0. cpu_rdata, cache_address, cache_data_in, mem_address, mem_wdata = 0. Burst counter = 0.
- Reset mid-operation aborts the transaction with no cpu_ready. The memory controller is reset by the same rst.
- IDLE:
  - On cpu_read or cpu_write (write has priority if both are set), latch address and data and drive cache_address.
  - Go to LOOKUP.
  - Requests are ignored in the cycle cpu_ready=1.
- LOOKUP (cache output valid this cycle):
  - Read hit: cpu_rdata = cache_data_out, cpu_ready=1, go to IDLE. Read-hit latency is 2 cycles from request to cpu_ready.
  - Read miss: go to FILL_CMD.
  - Write, hit or miss: if hit, pulse cache_write_enable with cpu_wdata this cycle. Then go to WRITE_CMD.
- FILL_CMD: mem_cmd_valid=1, mem_cmd_write=0, mem_address = latched address with column and zero bits cleared. On accept, go to FILL.
- FILL:
  - On each mem_rdata_valid: cache_address column = burst counter, cache_data_in = mem_rdata, cache_write_enable=1, counter++.
  - The word whose column equals the requested column is captured into cpu_rdata.
  - After the 4th strobe (counter wraps 3→0): cpu_ready=1 next cycle, go to IDLE. The cache is not re-read.
- WRITE_CMD: mem_cmd_valid=1, mem_cmd_write=1, mem_address/mem_wdata = latched values. On accept, go to WRITE_WAIT.
- WRITE_WAIT: on mem_write_done, cpu_ready=1, go to IDLE.
- mem_cmd_valid, once raised, is held with stable fields until accepted.
- mem_rdata_valid outside FILL is ignored. More than 4 strobes per burst is a memory protocol error; behaviour is undefined.
- Write miss never touches the cache (no allocate). Write hit updates the cache before the memory write; the line stays valid.
- cache_write_enable is never high in IDLE, FILL_CMD, WRITE_CMD or WRITE_WAIT.

Test Plan:
- Cold read 0x0000_0104 (line 0x10, column 1); memory returns A0..A3 with gaps between strobes → one burst at mem_address 0x0000_0100; 4 cache writes to columns 0..3; cpu_rdata=A1 with a single cpu_ready pulse.
- Repeat read 0x0000_010C after the fill → no mem_cmd_valid; cpu_ready 2 cycles after the request; cpu_rdata=A3.
- Write 0xDEADBEEF to 0x0000_0108 (hit), then read it → cache write plus memory write of 0xDEADBEEF at 0x108; read hit returns 0xDEADBEEF.
- Write miss to 0x0000_2000 with mem_cmd_ready held low 5 cycles → mem_cmd_valid and fields stable throughout; no cache_write_enable; cpu_ready only after mem_write_done.
- Conflict read 0x0000_1104 (same line index, different tag) → miss, refill overwrites line 0x10; a subsequent read of 0x0000_0104 misses again.
- rst asserted during the 2nd burst word → outputs go to 0 immediately; IDLE; no cpu_ready; a next read completes normally.
